// File: rtl/fifo_param.sv
// Parametrised single-clock FIFO with status FSM, occupancy counter and almost-flags.
// Define FIFO_SIMUL_RW_EN to allow a write and a read to complete on the same edge.
module fifo_param #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 3,
    parameter int AF_TH      = 6,
    parameter int AE_TH      = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [DATA_WIDTH-1:0] d_in,
    output logic [DATA_WIDTH-1:0] d_out,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  wr_ack,
    output logic                  wr_err,
    output logic                  rd_ack,
    output logic                  rd_err,
    output logic [ADDR_WIDTH:0]   data_count,
    output logic [2:0]            state
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0]   DEPTH_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0]   AF_CNT    = (ADDR_WIDTH+1)'(AF_TH);
    localparam logic [ADDR_WIDTH:0]   AE_CNT    = (ADDR_WIDTH+1)'(AE_TH);
    localparam logic [ADDR_WIDTH:0]   CNT_ZERO  = (ADDR_WIDTH+1)'(0);
    localparam logic [ADDR_WIDTH:0]   CNT_ONE   = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ZERO  = ADDR_WIDTH'(0);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = ADDR_WIDTH'(1);

    typedef enum logic [2:0] {
        ST_INIT     = 3'b000,
        ST_NO_OP    = 3'b001,
        ST_WRITE    = 3'b010,
        ST_WR_ERROR = 3'b011,
        ST_READ     = 3'b100,
        ST_RD_ERROR = 3'b101,
        ST_RW       = 3'b110
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0]   rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]     count_q, count_d;
    logic [DATA_WIDTH-1:0]   d_out_q, d_out_d;
    logic                    do_wr_s, do_rd_s;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    // Next state depends only on the requests and occupancy, never on the current state.
    always_comb begin
        state_d = ST_NO_OP;
        case ({wr_en, rd_en})
            2'b00: state_d = ST_NO_OP;
            2'b10: state_d = (count_q < DEPTH_CNT) ? ST_WRITE : ST_WR_ERROR;
            2'b01: state_d = (count_q != CNT_ZERO) ? ST_READ : ST_RD_ERROR;
            2'b11: begin
`ifdef FIFO_SIMUL_RW_EN
                state_d = (count_q == CNT_ZERO) ? ST_WRITE : ST_RW;
`else
                state_d = ST_NO_OP;
`endif
            end
            default: state_d = ST_NO_OP;
        endcase
    end

    // Datapath acts on the edge that enters WRITE/READ/RW.
    always_comb begin
        do_wr_s  = (state_d == ST_WRITE) || (state_d == ST_RW);
        do_rd_s  = (state_d == ST_READ)  || (state_d == ST_RW);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        d_out_d  = d_out_q;
        if (do_wr_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_rd_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
            d_out_d  = mem[rd_ptr_q];
        end else begin
            rd_ptr_d = rd_ptr_q;
            d_out_d  = d_out_q;
        end
        case ({do_wr_s, do_rd_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Control and pointer registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_INIT;
            wr_ptr_q <= PTR_ZERO;
            rd_ptr_q <= PTR_ZERO;
            count_q  <= CNT_ZERO;
            d_out_q  <= {DATA_WIDTH{1'b0}};
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            d_out_q  <= d_out_d;
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (do_wr_s) begin
            mem[wr_ptr_q] <= d_in;
        end
    end

    assign d_out        = d_out_q;
    assign data_count   = count_q;
    assign state        = state_q;
    assign full         = (count_q == DEPTH_CNT);
    assign empty        = (count_q == CNT_ZERO);
    assign almost_full  = (count_q >= AF_CNT);
    assign almost_empty = (count_q <= AE_CNT);
    assign wr_ack       = (state_q == ST_WRITE) || (state_q == ST_RW);
    assign rd_ack       = (state_q == ST_READ)  || (state_q == ST_RW);
    assign wr_err       = (state_q == ST_WR_ERROR);
    assign rd_err       = (state_q == ST_RD_ERROR);

endmodule
